// File: rtl/seq_mult_shift_add.sv
// Multi-cycle unsigned shift-and-add multiplier with a start/busy/done handshake.
// It runs one partial-product addition per clock, and the product is held until the next accepted start.
module seq_mult_shift_add #(
   parameter int unsigned N  = 4,
   parameter int unsigned CW = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   output logic             busy,
   output logic             done,
   output logic [2*N-1:0]   product
);

   localparam int unsigned AW = 2 * N + 1;
   localparam int unsigned PW = 2 * N;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   mcand_q, mcand_d;
   logic [AW-1:0]  acc_q, acc_d;
   logic [CW-1:0]  count_q, count_d;
   logic [PW-1:0]  product_q, product_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [N-1:0]   addend_c;
   logic [N:0]     sum_c;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state, iteration datapath and registered-output decode
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      count_d   = count_q;
      product_d = product_q;
      addend_c  = '0;
      sum_c     = '0;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mcand_d = a;
               acc_d   = {{(N + 1){1'b0}}, b};
               count_d = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // acc_q[2N] is always 0 here, so the top slice is the upper half zero-extended.
            addend_c = acc_q[0] ? mcand_q : '0;
            sum_c    = acc_q[2*N:N] + {1'b0, addend_c};
            acc_d    = {1'b0, sum_c, acc_q[N-1:1]};
            count_d  = count_q + CW'(1);
            if (count_q == CW'(N - 1)) begin
               state_d   = DONE;
               product_d = acc_d[PW-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Directed bench for seq_mult_shift_add, using N=4 and N=8 instances and immediate-assertion checks.
module tb_seq_mult_shift_add;

   logic        clk;
   logic        rst_n;
   logic        start4, start8;
   logic [3:0]  a4, b4;
   logic [7:0]  a8, b8;
   logic        busy4, done4, busy8, done8;
   logic [7:0]  product4;
   logic [15:0] product8;

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   logic [15:0] prev4 = '0;
   logic [15:0] prev8 = '0;

   seq_mult_shift_add #(.N(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .product(product4)
   );

   seq_mult_shift_add #(.N(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .product(product8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] get_busy(input bit w8);
      return w8 ? 16'(busy8) : 16'(busy4);
   endfunction

   function automatic logic [15:0] get_done(input bit w8);
      return w8 ? 16'(done8) : 16'(done4);
   endfunction

   function automatic logic [15:0] get_prod(input bit w8);
      return w8 ? product8 : 16'(product4);
   endfunction

   task automatic drive(input bit w8, input logic s, input logic [7:0] av, input logic [7:0] bv);
      if (w8) begin
         start8 = s; a8 = av; b8 = bv;
      end else begin
         start4 = s; a4 = av[3:0]; b4 = bv[3:0];
      end
   endtask

   // One operation, called at a negedge. When pre_started is set, start was already driven.
   // inject drives a new start on RUN cycle 2; chain drives the next start during the done cycle.
   task automatic op(input string tag, input bit w8, input logic [7:0] av, input logic [7:0] bv,
                     input logic [15:0] exp, input bit pre_started, input bit inject,
                     input bit chain, input logic [7:0] na, input logic [7:0] nb);
      int n;
      int done_seen;
      logic [15:0] prev;
      n = w8 ? 8 : 4;
      done_seen = 0;
      prev = w8 ? prev8 : prev4;
      if (!pre_started) drive(w8, 1'b1, av, bv);
      @(negedge clk);
      drive(w8, 1'b0, av, bv);
      for (int i = 0; i < n; i++) begin
         check({tag, "_busy"}, get_busy(w8), 16'd1);
         if (get_done(w8) === 1'b1) done_seen++;
         if (i == 0) check({tag, "_hold"}, get_prod(w8), prev);
         if (inject && i == 1) drive(w8, 1'b1, 8'hFF, 8'hFF);
         if (inject && i == 2) drive(w8, 1'b0, av, bv);
         @(negedge clk);
      end
      check({tag, "_nodone_run"}, 16'(done_seen), 16'd0);
      check({tag, "_done"}, get_done(w8), 16'd1);
      check({tag, "_busy_off"}, get_busy(w8), 16'd0);
      check({tag, "_prod"}, get_prod(w8), exp);
      if (w8) prev8 = exp; else prev4 = exp;
      if (chain) begin
         drive(w8, 1'b1, na, nb);
      end else begin
         @(negedge clk);
         check({tag, "_done_off"}, get_done(w8), 16'd0);
         check({tag, "_prod_keep"}, get_prod(w8), exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0;
      start8 = 1'b0; a8 = '0; b8 = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 16'(busy4), 16'd0);
      check("rst_done", 16'(done4), 16'd0);
      check("rst_prod", 16'(product4), 16'd0);
      check("rst_prod8", product8, 16'd0);
      rst_n = 1'b1;

      op("m3x5", 1'b0, 8'h3, 8'h5, 16'h0F, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0);
      op("mFxF", 1'b0, 8'hF, 8'hF, 16'hE1, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0);
      op("n8FFxFF", 1'b1, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0);
      op("zero", 1'b0, 8'h0, 8'h9, 16'h00, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0);
      op("inj7x6", 1'b0, 8'h7, 8'h6, 16'h2A, 1'b0, 1'b1, 1'b0, 8'h0, 8'h0);

      // Back-to-back: the second start is driven during the done cycle of the first op.
      op("b2b_2x3", 1'b0, 8'h2, 8'h3, 16'h06, 1'b0, 1'b0, 1'b1, 8'h4, 8'h4);
      op("b2b_4x4", 1'b0, 8'h4, 8'h4, 16'h10, 1'b1, 1'b0, 1'b0, 8'h0, 8'h0);

      // Asynchronous reset in RUN cycle 2, between clock edges.
      drive(1'b0, 1'b1, 8'hD, 8'hB);
      @(negedge clk);
      drive(1'b0, 1'b0, 8'hD, 8'hB);
      @(negedge clk);
      check("mid_busy_pre", 16'(busy4), 16'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 16'(busy4), 16'd0);
      check("mid_rst_done", 16'(done4), 16'd0);
      check("mid_rst_prod", 16'(product4), 16'd0);
      check("mid_rst_prod8", product8, 16'd0);
      prev4 = '0;
      prev8 = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_hold_busy", 16'(busy4), 16'd0);
      rst_n = 1'b1;
      op("post_2x2", 1'b0, 8'h2, 8'h2, 16'h04, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/seq_mult_shift_add.md
Name: seq_mult_shift_add

Overview:
- Multi-cycle unsigned shift-and-add multiplier for the CPU datapath.
- Sits directly downstream of the N-bit ripple-carry adder stage. Each iteration feeds one partial-product addition through an N-bit add that produces an (N+1)-bit result.
- Uses a start/busy/done handshake and holds the 2N-bit product until the next accepted start.

Parameters:
- N, 4, operand width in bits; N >= 2.
- CW, $clog2(N+1), width of the internal iteration counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  request; sampled on the rising edge; accepted only in IDLE or DONE.
- a  input  N  multiplicand; captured on an accepted start.
- b  input  N  multiplier; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; high only in DONE.
- product  output  2N  result; valid from the DONE cycle until the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous, at any time including mid-RUN):
  - State goes to IDLE.
  - busy=0, done=0, product=0.
  - Internal registers clear: mcand, acc (2N+1 bits), count.
  - Any in-flight operation is abandoned with no partial result visible.
  - Release is synchronous to clk; the first edge with rst_n high may accept start.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - mcand <= a.
  - acc <= {(N+1)'b0, b}.
  - count <= 0.
  - Next state RUN.
- IDLE, start=0: hold.
- RUN, one iteration per clock:
  - sum[N:0] = acc[2N-1:N] + (acc[0] ? mcand : 0), an N+1 bit result; the carry is the sum MSB.
  - acc <= {1'b0, sum, acc[N-1:1]}, a logical right shift of the carry, sum and low half.
  - count <= count+1.
  - When count == N-1 at the edge, next state is DONE.
- RUN latency:
  - Exactly N RUN cycles.
  - Start accepted at edge k gives busy=1 after edges k..k+N-1.
  - done=1 and product valid after edge k+N.
  - After edge k+N+1, done=0.
- Entering DONE: product <= acc[2N-1:0]; the internal bit 2N is always 0 at completion.
- DONE, start=1:
  - Accepted exactly as in IDLE, so back-to-back operations add no idle bubble.
  - done drops and busy rises on that edge.
- DONE, start=0: next state IDLE.
- start during RUN: ignored, with no effect on operands, counter or result.
- product output:
  - Registered.
  - Changes only on entry to DONE or on reset.
  - Holds through IDLE and through a subsequent RUN until the new result lands.
- busy and done are never high simultaneously.
- Zero operands:
  - No special-casing; the full N cycles are still spent.
  - The result is 0.
- Arithmetic:
  - Unsigned only.
  - No overflow is possible: the full 2N-bit product is always representable.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset then 3×5, N=4: start=1 one cycle with a=4'h3, b=4'h5 -> busy high for 4 cycles, then done pulses for 1 cycle with product=8'h0F; product stays 8'h0F after done falls.
- Max operands, N=4: a=4'hF, b=4'hF -> product=8'hE1 at the done cycle.
- Max operands, N=8 instance: a=8'hFF, b=8'hFF -> product=16'hFE01 after 8 busy cycles.
- Zero operand: a=4'h0, b=4'h9 -> 4 busy cycles, then product=8'h00.
- Start during RUN ignored: a=4'h7, b=4'h6 accepted; assert start with a=4'hF, b=4'hF on RUN cycle 2 -> product=8'h2A, done pulses exactly once, with latency unchanged.
- Back-to-back start in DONE: after a 2×3 run, assert start with a=4'h4, b=4'h4 during the done cycle:
  - done=1 shows product=8'h06.
  - The next edge sets busy=1 and done=0.
  - 4 cycles later, done shows product=8'h10.
  - No idle cycle between the two runs.
- Reset mid-operation: a=4'hD, b=4'hB started; drop rst_n asynchronously (between edges) in RUN cycle 2:
  - busy, done and product go to 0 immediately.
  - After release, a new 2×2 run gives product=8'h04 with normal latency.
